// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    localparam int FETCH_PC_W    = 16;
    localparam int FETCH_INSTR_W = 16;

    localparam logic [FETCH_INSTR_W-1:0] HALT_OPCODE = 16'hFFFF;

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_PC_W-1:0]    pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; the head entry is read straight from storage at the read pointer.
module fetch_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [DATA_W-1:0]          push_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic [DATA_W-1:0]          head_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: PC register, fetch/halt FSM and a buffer of {pc, instr} pairs.
// Optional saturating perf counters are built when FETCH_PERF_EN is defined.
//
//   state  | meaning
//   FETCH  | push one instruction per cycle while buffer has room
//   HALTED | HALT opcode pushed; idle until a redirect
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              PC_W       = 16,
    parameter int              INSTR_W    = 16,
    parameter int              ADDR_W     = 4,
    parameter int              FIFO_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC   = 16'h0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [3:0]         out_alu_sel,
    output logic               halted,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stalls
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t             state_q, state_d;
    logic [PC_W-1:0]          pc_q, pc_d;
    logic [CNT_W-1:0]         fifo_count;
    logic [PC_W+INSTR_W-1:0]  head_data;
    logic                     fifo_full;
    logic                     push;
    logic                     pop;

    assign imem_addr = pc_q[ADDR_W-1:0];
    assign fifo_full = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid & out_ready;
    // A pop frees a slot in the same cycle, so a full buffer still streams.
    assign push      = (state_q == FETCH) & ~redirect_valid & (~fifo_full | pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (redirect_valid) begin
            state_d = FETCH;
            pc_d    = redirect_pc;
        end else if (push) begin
            pc_d = pc_q + PC_W'(1);
            if (imem_instr == INSTR_W'(HALT_OPCODE)) state_d = HALTED;
        end
    end

    fetch_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (PC_W + INSTR_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_data ({pc_q, imem_instr}),
        .count     (fifo_count),
        .head_data (head_data)
    );

    assign out_pc      = head_data[PC_W+INSTR_W-1:INSTR_W];
    assign out_instr   = head_data[INSTR_W-1:0];
    assign out_alu_sel = out_instr[3:0];
    assign halted      = (state_q == HALTED);

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q;
    logic [31:0] stalls_q;
    logic        stall;

    assign stall = (state_q == FETCH) & ~redirect_valid & ~push;

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetched_q <= '0;
            stalls_q  <= '0;
        end else begin
            if (push  && fetched_q != '1) fetched_q <= fetched_q + 32'd1;
            if (stall && stalls_q  != '1) stalls_q  <= stalls_q + 32'd1;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_stalls  = stalls_q;
`else
    assign perf_fetched = 32'd0;
    assign perf_stalls  = 32'd0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed vector bench for instr_fetch_unit; imem model returns addr*3, or FFFF at addr 5 when enabled.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic [3:0]  imem_addr;
    logic [15:0] imem_instr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic [3:0]  out_alu_sel;
    logic        halted;
    logic [31:0] perf_fetched;
    logic [31:0] perf_stalls;
    logic        hlt_en;

    int applied = 0;
    int errors  = 0;

`ifdef FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    always #5 clk = ~clk;

    assign imem_instr = (hlt_en && imem_addr == 4'd5) ? 16'hFFFF : 16'(imem_addr) * 16'd3;

    instr_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_alu_sel    (out_alu_sel),
        .halted         (halted),
        .perf_fetched   (perf_fetched),
        .perf_stalls    (perf_stalls)
    );

    typedef struct {
        logic        rst_n;
        logic        rdr;
        logic [15:0] rdr_pc;
        logic        rdy;
        logic        hen;
        logic        e_valid;
        logic [15:0] e_pc;
        logic [15:0] e_instr;
        logic        e_halted;
        logic [3:0]  e_addr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic r, logic d, logic [15:0] dp, logic y, logic h,
                               logic ev, logic [15:0] ep, logic [15:0] ei, logic eh, logic [3:0] ea);
        vec_t t;
        t.rst_n = r; t.rdr = d; t.rdr_pc = dp; t.rdy = y; t.hen = h;
        t.e_valid = ev; t.e_pc = ep; t.e_instr = ei; t.e_halted = eh; t.e_addr = ea;
        return t;
    endfunction

    task automatic step(input vec_t t);
        reset          = t.rst_n;
        redirect_valid = t.rdr;
        redirect_pc    = t.rdr_pc;
        out_ready      = t.rdy;
        hlt_en         = t.hen;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_vec(input int i, input vec_t t);
        applied++;
        check($sformatf("v%0d valid", i), 32'(out_valid), 32'(t.e_valid));
        check($sformatf("v%0d halted", i), 32'(halted), 32'(t.e_halted));
        check($sformatf("v%0d imem_addr", i), 32'(imem_addr), 32'(t.e_addr));
        if (t.e_valid) begin
            check($sformatf("v%0d out_pc", i), 32'(out_pc), 32'(t.e_pc));
            check($sformatf("v%0d out_instr", i), 32'(out_instr), 32'(t.e_instr));
            check($sformatf("v%0d alu_sel", i), 32'(out_alu_sel), 32'(t.e_instr[3:0]));
        end
    endtask

    initial begin
        // 1: free-running after reset
        vecs.push_back(v(0,0,0,1,0, 0,0,0,0,0));
        for (int k = 1; k <= 4; k++)
            vecs.push_back(v(1,0,0,1,0, 1,16'(k-1),16'(3*(k-1)),0,4'(k)));
        // 2: consumer stalls, buffer fills, then release with push+pop on full
        vecs.push_back(v(0,0,0,0,0, 0,0,0,0,0));
        for (int k = 1; k <= 10; k++)
            vecs.push_back(v(1,0,0,0,0, 1,0,0,0,4'(k < 4 ? k : 4)));
        for (int k = 1; k <= 4; k++)
            vecs.push_back(v(1,0,0,1,0, 1,16'(k),16'(3*k),0,4'(4+k)));
        // 3: redirect while full with a same-cycle pop
        vecs.push_back(v(0,0,0,0,0, 0,0,0,0,0));
        for (int k = 1; k <= 4; k++)
            vecs.push_back(v(1,0,0,0,0, 1,0,0,0,4'(k)));
        vecs.push_back(v(1,1,16'h0040,1,0, 0,0,0,0,4'h0));
        vecs.push_back(v(1,0,0,1,0, 1,16'h0040,0,0,4'h1));
        vecs.push_back(v(1,0,0,1,0, 1,16'h0041,3,0,4'h2));
        // 4: HALT at pc 5, then redirect out of HALTED
        vecs.push_back(v(0,0,0,1,1, 0,0,0,0,0));
        for (int k = 1; k <= 5; k++)
            vecs.push_back(v(1,0,0,1,1, 1,16'(k-1),16'(3*(k-1)),0,4'(k)));
        vecs.push_back(v(1,0,0,1,1, 1,16'd5,16'hFFFF,1,4'd6));
        vecs.push_back(v(1,0,0,1,1, 0,0,0,1,4'd6));
        vecs.push_back(v(1,0,0,1,1, 0,0,0,1,4'd6));
        vecs.push_back(v(1,1,16'h0000,1,0, 0,0,0,0,4'd0));
        vecs.push_back(v(1,0,0,1,0, 1,16'd0,16'd0,0,4'd1));
        // 5: PC wraps past FFFF
        vecs.push_back(v(1,1,16'hFFFE,1,0, 0,0,0,0,4'hE));
        vecs.push_back(v(1,0,0,1,0, 1,16'hFFFE,16'h002A,0,4'hF));
        vecs.push_back(v(1,0,0,1,0, 1,16'hFFFF,16'h002D,0,4'h0));
        vecs.push_back(v(1,0,0,1,0, 1,16'h0000,16'h0000,0,4'h1));
        // 6: reset with entries buffered
        vecs.push_back(v(0,0,0,0,0, 0,0,0,0,0));
        for (int k = 1; k <= 3; k++)
            vecs.push_back(v(1,0,0,0,0, 1,0,0,0,4'(k)));
        vecs.push_back(v(0,0,0,0,0, 0,0,0,0,4'd0));
        vecs.push_back(v(1,0,0,1,0, 1,16'd0,16'd0,0,4'd1));

        foreach (vecs[i]) begin
            step(vecs[i]);
            check_vec(i, vecs[i]);
        end

        // Perf counters: fill with consumer stalled, then halt and confirm pushes stop.
        step(v(0,0,0,0,0, 0,0,0,0,0));
        applied++;
        check("perf_fetched reset", perf_fetched, 32'd0);
        check("perf_stalls reset", perf_stalls, 32'd0);
        for (int k = 0; k < 10; k++) step(v(1,0,0,0,0, 0,0,0,0,0));
        applied++;
        check("perf_fetched stall", perf_fetched, PERF ? 32'd4 : 32'd0);
        check("perf_stalls stall", perf_stalls, PERF ? 32'd6 : 32'd0);
        check("stall pc", 32'(imem_addr), 32'd4);
        // Redirect during a stall counts as neither push nor stall.
        step(v(1,1,16'h0003,0,1, 0,0,0,0,0));
        for (int k = 0; k < 6; k++) step(v(1,0,0,1,1, 0,0,0,0,0));
        applied++;
        check("halt flag", 32'(halted), 32'd1);
        check("halt pc", 32'(imem_addr), 32'd6);
        check("halt drained", 32'(out_valid), 32'd0);
        check("perf_fetched halt", perf_fetched, PERF ? 32'd7 : 32'd0);
        check("perf_stalls halt", perf_stalls, PERF ? 32'd6 : 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
        $finish;
    end

endmodule
